// File: rtl/soc_test_monitor_if.sv
// Snooped data-memory write port.
//   wr_valid / wr_ready : write handshake; a write is accepted when both are high
//   wr_addr             : byte address of the write
//   wr_data             : write data
// master drives a write, slave accepts it, monitor only observes.
interface soc_test_monitor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master  (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave   (input wr_valid, wr_addr, wr_data, output wr_ready);
  modport monitor (input wr_valid, wr_ready, wr_addr, wr_data);
endinterface

// File: rtl/soc_test_monitor.sv
// Completion / watchdog monitor for a SoC test run.
// Watches the data-memory write port and the core retire strobe. A non-zero
// write to TOHOST_ADDR ends the run (1 = PASS, else FAIL with code data>>1);
// writes into the result window are summed and counted. A run that exceeds
// TIMEOUT_CYCLES, or goes STALL_CYCLES cycles without a retire, is flagged.
// Ports:
//   clk, rst (async active-low), start (pulse: clear and enter RUN), retire
//   wr            : snooped write port (monitor modport)
//   status, done  : run state, done high in any terminal state
//   fail_code     : data>>1 of the failing tohost write
//   cycle_count, retire_count, result_sum, result_writes : run statistics
module soc_test_monitor #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0000_1FFC,
  parameter logic [ADDR_WIDTH-1:0] RESULT_BASE    = 32'h0000_3000,
  parameter int                    RESULT_WORDS   = 16,
  parameter int                    TIMEOUT_CYCLES = 5000,
  parameter int                    STALL_CYCLES   = 256,
  parameter int                    CNT_WIDTH      = 32,
  localparam int                   RW_W           = $clog2(RESULT_WORDS+1)+8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  retire,
  soc_test_monitor_if.monitor   wr,
  output logic [2:0]            status,
  output logic                  done,
  output logic [DATA_WIDTH-2:0] fail_code,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  retire_count,
  output logic [DATA_WIDTH-1:0] result_sum,
  output logic [RW_W-1:0]       result_writes
);

  localparam int SW = $clog2(STALL_CYCLES+1);
  localparam logic [ADDR_WIDTH-1:0] RES_END =
    ADDR_WIDTH'(RESULT_BASE + RESULT_WORDS*(DATA_WIDTH/8));

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_PASS = 3'd2,
    S_FAIL = 3'd3, S_TIMEOUT = 3'd4, S_HANG = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [SW-1:0]         stall, stall_n;
  logic [CNT_WIDTH-1:0]  cyc_n, ret_n;
  logic [DATA_WIDTH-1:0] sum_n;
  logic [RW_W-1:0]       rw_n;
  logic [DATA_WIDTH-2:0] fc_n;
  logic                  acc, in_win, to_host;

  assign acc     = wr.wr_valid & wr.wr_ready;
  assign in_win  = acc && (wr.wr_addr >= RESULT_BASE) && (wr.wr_addr < RES_END);
  assign to_host = acc && (wr.wr_addr == TOHOST_ADDR) && (wr.wr_data != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      stall         <= '0;
      cycle_count   <= '0;
      retire_count  <= '0;
      result_sum    <= '0;
      result_writes <= '0;
      fail_code     <= '0;
    end else begin
      state         <= state_n;
      stall         <= stall_n;
      cycle_count   <= cyc_n;
      retire_count  <= ret_n;
      result_sum    <= sum_n;
      result_writes <= rw_n;
      fail_code     <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    stall_n = stall;
    cyc_n   = cycle_count;
    ret_n   = retire_count;
    sum_n   = result_sum;
    rw_n    = result_writes;
    fc_n    = fail_code;
    if (start) begin
      // start from any state (including RUN) begins a fresh run; whatever
      // write or retire arrives in this cycle belongs to no run.
      state_n = S_RUN;
      stall_n = '0;
      cyc_n   = '0;
      ret_n   = '0;
      sum_n   = '0;
      rw_n    = '0;
      fc_n    = '0;
    end else if (state == S_RUN) begin
      cyc_n = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
      if (retire) begin
        ret_n   = (&retire_count) ? retire_count : retire_count + 1'b1;
        stall_n = '0;
      end else begin
        // exits at STALL_CYCLES, so this never overflows
        stall_n = stall + 1'b1;
      end
      if (in_win) begin
        sum_n = result_sum + wr.wr_data;
        rw_n  = (&result_writes) ? result_writes : result_writes + 1'b1;
      end
      // exit priority: tohost, then hang, then timeout
      if (to_host) begin
        if (wr.wr_data == DATA_WIDTH'(1)) begin
          state_n = S_PASS;
        end else begin
          state_n = S_FAIL;
          fc_n    = wr.wr_data[DATA_WIDTH-1:1];
        end
      end else if (stall_n == SW'(STALL_CYCLES)) begin
        state_n = S_HANG;
      end else if (cyc_n == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
        state_n = S_TIMEOUT;
      end
    end
  end

  assign status = state;
  assign done   = state inside {S_PASS, S_FAIL, S_TIMEOUT, S_HANG};

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed bench for soc_test_monitor with a per-cycle reference model.
module tb_soc_test_monitor;
  localparam int RW_W = $clog2(16+1)+8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        retire = 1'b0;
  logic [2:0]  status;
  logic        done;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, retire_count, result_sum;
  logic [RW_W-1:0] result_writes;

  soc_test_monitor_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  soc_test_monitor dut (
    .clk(clk), .rst(rst), .start(start), .retire(retire), .wr(bus.monitor),
    .status(status), .done(done), .fail_code(fail_code),
    .cycle_count(cycle_count), .retire_count(retire_count),
    .result_sum(result_sum), .result_writes(result_writes)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: run length, last retire position and window bookkeeping.
  int          m_state = 0;
  int          m_cyc = 0, m_ret = 0, m_last = 0, m_rw = 0;
  logic [31:0] m_sum = '0;
  logic [30:0] m_fc = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cyc = 0; m_ret = 0; m_last = 0; m_rw = 0; m_sum = '0; m_fc = '0;
  endtask

  task automatic model_step();
    logic acc;
    if (start) begin
      model_clear();
      m_state = 1;
    end else if (m_state == 1) begin
      m_cyc++;
      if (retire) begin m_ret++; m_last = m_cyc; end
      acc = bus.wr_valid && bus.wr_ready;
      if (acc && bus.wr_addr >= 32'h3000 && bus.wr_addr < 32'h3000 + 16*4) begin
        m_sum = m_sum + bus.wr_data;
        m_rw++;
      end
      if (acc && bus.wr_addr == 32'h1FFC && bus.wr_data != 0) begin
        if (bus.wr_data == 1) m_state = 2;
        else begin m_state = 3; m_fc = bus.wr_data[31:1]; end
      end else if (m_cyc - m_last >= 256) m_state = 5;
      else if (m_cyc >= 5000) m_state = 4;
    end
  endtask

  // One clock: the model consumes the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic drive(input logic st, input logic rt, input logic v, input logic rdy,
                       input logic [31:0] a, input logic [31:0] d);
    start = st; retire = rt;
    bus.wr_valid = v; bus.wr_ready = rdy; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  task automatic do_start();
    drive(1, 0, 0, 1, 32'h0, 32'h0); tick(); idle();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("status", status, m_state);
      chk("done", done, (m_state >= 2));
      chk("fail_code", fail_code, m_fc);
      chk("cycle_count", cycle_count, m_cyc);
      chk("retire_count", retire_count, m_ret);
      chk("result_sum", result_sum, m_sum);
      chk("result_writes", result_writes, m_rw);
    end
  end

  initial begin
    int n;
    idle();
    tick(); tick();
    chk("rst_status", status, 3'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_cycles", cycle_count, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // IDLE ignores retires and writes
    drive(0, 1, 1, 1, 32'h1FFC, 32'h1); tick();
    drive(0, 1, 1, 1, 32'h3000, 32'h9); tick();
    idle(); tick();
    chk("idle_status", status, 3'd0);
    chk("idle_retires", retire_count, 32'd0);
    chk("idle_writes", result_writes, 0);

    // PASS after 10 retires
    do_start();
    for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 1, 0, 0); tick(); end
    drive(0, 0, 1, 1, 32'h1FFC, 32'h1); tick();
    idle(); tick();
    chk("pass_status", status, 3'd2);
    chk("pass_done", done, 1'b1);
    chk("pass_cycles", cycle_count, 32'd11);
    chk("pass_retires", retire_count, 32'd10);
    chk("pass_fcode", fail_code, 31'd0);

    // tohost 0 ignored, then FAIL with code 5; later writes do nothing
    do_start();
    drive(0, 0, 1, 1, 32'h1FFC, 32'h0); tick();
    chk("zero_ignored", status, 3'd1);
    drive(0, 0, 1, 1, 32'h1FFC, 32'hB); tick();
    chk("fail_status", status, 3'd3);
    chk("fail_fcode", fail_code, 31'd5);
    drive(0, 1, 1, 1, 32'h1FFC, 32'h1); tick();
    drive(0, 1, 1, 1, 32'h3000, 32'h4); tick();
    idle(); tick();
    chk("fail_hold_status", status, 3'd3);
    chk("fail_hold_fcode", fail_code, 31'd5);
    chk("fail_hold_cycles", cycle_count, 32'd2);
    chk("fail_hold_sum", result_sum, 32'd0);

    // TIMEOUT after exactly 5000 RUN cycles with steady retires
    do_start();
    n = 0;
    while (n < 6000 && status != 3'd4) begin drive(0, 1, 0, 1, 0, 0); tick(); n++; end
    idle(); tick();
    chk("timeout_cycles_waited", n, 5000);
    chk("timeout_status", status, 3'd4);
    chk("timeout_count", cycle_count, 32'd5000);
    chk("timeout_retires", retire_count, 32'd5000);

    // HANG: retires stop after cycle 20
    do_start();
    for (int i = 0; i < 20; i++) begin drive(0, 1, 0, 1, 0, 0); tick(); end
    n = 0;
    idle();
    while (n < 400 && !done) begin tick(); n++; end
    chk("hang_status", status, 3'd5);
    chk("hang_cycles", cycle_count, 32'd276);
    chk("hang_retires", retire_count, 32'd20);

    // same-cycle tohost PASS beats HANG
    do_start();
    for (int i = 0; i < 20; i++) begin drive(0, 1, 0, 1, 0, 0); tick(); end
    idle();
    for (int i = 0; i < 255; i++) tick();
    chk("prehang_status", status, 3'd1);
    drive(0, 0, 1, 1, 32'h1FFC, 32'h1); tick();
    idle(); tick();
    chk("pass_over_hang", status, 3'd2);
    chk("pass_over_hang_cycles", cycle_count, 32'd276);

    // result window accumulation
    do_start();
    drive(0, 0, 1, 1, 32'h3000, 32'd3); tick();
    drive(0, 0, 1, 1, 32'h3004, 32'd4); tick();
    drive(0, 0, 1, 1, 32'h303C, 32'hFFFF_FFFF); tick();
    drive(0, 0, 1, 1, 32'h3040, 32'd7); tick();
    drive(0, 0, 1, 0, 32'h3008, 32'd9); tick();
    drive(0, 0, 1, 1, 32'h2FFC, 32'd1); tick();
    drive(0, 0, 0, 1, 32'h3008, 32'd2); tick();
    idle(); tick();
    chk("win_writes", result_writes, 3);
    chk("win_sum", result_sum, 32'd6);
    chk("win_status", status, 3'd1);
    // restart in RUN drops the in-flight write
    drive(1, 1, 1, 1, 32'h3000, 32'd5); tick();
    idle();
    chk("restart_writes", result_writes, 0);
    chk("restart_sum", result_sum, 32'd0);
    chk("restart_cycles", cycle_count, 32'd0);
    chk("restart_status", status, 3'd1);

    // reset mid-RUN at cycle 100
    for (int i = 0; i < 100; i++) begin drive(0, 1, 1, 1, 32'h3010, 32'd1); tick(); end
    idle();
    #2;
    rst = 1'b0;
    m_state = 0; model_clear();
    #1;
    chk("midrst_status", status, 3'd0);
    chk("midrst_cycles", cycle_count, 32'd0);
    chk("midrst_retires", retire_count, 32'd0);
    chk("midrst_sum", result_sum, 32'd0);
    chk("midrst_writes", result_writes, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    do_start();
    chk("rerun_cycles0", cycle_count, 32'd0);
    chk("rerun_status", status, 3'd1);
    drive(0, 1, 0, 1, 0, 0); tick();
    idle(); tick();
    chk("rerun_cycles2", cycle_count, 32'd2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d compared, want completion", n_cmp);
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/soc_test_monitor.md
Name: soc_test_monitor

Overview:
Synthesizable completion and watchdog monitor attached to the SoC data-memory write port and the core retire signal. It replaces fixed-delay test benches: it detects a program's pass/fail signature written to a tohost address, and accumulates a checksum of writes into a parametrised result window. It also flags global timeouts and retire stalls (hangs). A bench instantiates it beside soc and waits on done instead of a fixed #delay.

Parameters:
ADDR_WIDTH, 32, byte address width of snooped write port
DATA_WIDTH, 32, write data width
TOHOST_ADDR, 32'h0000_1FFC, address whose write ends the test
RESULT_BASE, 32'h0000_3000, first byte address of result window (word aligned)
RESULT_WORDS, 16, number of DATA_WIDTH/8-byte words in result window (>=1)
TIMEOUT_CYCLES, 5000, max RUN cycles before TIMEOUT (>=1)
STALL_CYCLES, 256, max consecutive RUN cycles without a retire before HANG (>=1)
CNT_WIDTH, 32, width of cycle and retire counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: clear counters, enter RUN
wr_valid  in  1  memory write request valid
wr_ready  in  1  memory accepts write; a write counts only when wr_valid & wr_ready
wr_addr  in  ADDR_WIDTH  write byte address
wr_data  in  DATA_WIDTH  write data
retire  in  1  core committed one instruction this cycle
status  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
done  out  1  high while status in {PASS, FAIL, TIMEOUT, HANG}
fail_code  out  DATA_WIDTH-1  wr_data>>1 of the failing tohost write, else 0
cycle_count  out  CNT_WIDTH  RUN cycles elapsed, saturating
retire_count  out  CNT_WIDTH  retires counted in RUN, saturating
result_sum  out  DATA_WIDTH  modulo-2^DATA_WIDTH sum of data written into result window
result_writes  out  $clog2(RESULT_WORDS+1)+8  accepted writes into result window, saturating

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release): status=IDLE, done=0, all counters, fail_code and result_sum = 0.
- IDLE: writes and retires are ignored. start -> RUN on the next edge, with all counters, result_sum and fail_code cleared.
- RUN, evaluated each cycle:
  - cycle_count +1.
  - stall counter +1, cleared on retire; retire also increments retire_count.
  - Accepted write with RESULT_BASE <= wr_addr < RESULT_BASE + RESULT_WORDS*DATA_WIDTH/8: result_sum += wr_data; result_writes +1.
  - Accepted write to TOHOST_ADDR with wr_data != 0:
    - wr_data == 1 -> PASS.
    - Otherwise -> FAIL, fail_code = wr_data>>1.
    - wr_data == 0 is ignored.
- Exit priority when several events occur in the same cycle: tohost write > HANG > TIMEOUT.
  - TIMEOUT when cycle_count reaches TIMEOUT_CYCLES, i.e. after exactly TIMEOUT_CYCLES RUN cycles.
  - HANG when the stall counter reaches STALL_CYCLES.
- The cycle that exits RUN still updates counters, including a retire in that cycle. The transition is registered: status changes one cycle after the triggering edge sample.
- Terminal states (PASS/FAIL/TIMEOUT/HANG) hold all outputs frozen until start or reset. start in a terminal state -> RUN with counters cleared.
- start while in RUN restarts RUN: counters cleared, in-flight write that cycle is dropped.
- Writes with wr_valid & !wr_ready are never counted.
- Result-window writes are not checked for alignment. The address compare is full width; wrap of RESULT_BASE + size beyond 2^ADDR_WIDTH is illegal configuration.
- Counters saturate at all-ones, never wrap.
- Reset asserted mid-RUN returns to IDLE immediately, clearing everything.

Test Plan:
- Reset, start, 10 retires then accepted write addr=0x1FFC data=1 -> status=PASS, done=1, cycle_count=11, retire_count=10, fail_code=0.
- Write 0x1FFC data=0x0000_000B -> status=FAIL, fail_code=5; later write data=1 while FAIL -> outputs unchanged.
- Start, retire every cycle, no tohost write, TIMEOUT_CYCLES=5000 -> status=TIMEOUT after exactly 5000 RUN cycles, cycle_count=5000.
- STALL_CYCLES=256, retires stop at cycle 20 -> HANG at stall count 256; same-cycle tohost data=1 in a repeat run -> PASS wins.
- Writes to 0x3000, 0x3004, 0x303C (data 3, 4, 0xFFFF_FFFF), 0x3040 (data 7), one with wr_ready=0 -> result_writes=3, result_sum=6.
- rst low mid-RUN at cycle 100 -> all outputs 0 immediately; start after release -> RUN with cycle_count restarting from 0.
